// File: rtl/ide_pio.sv
// PIO-mode ATA/IDE host engine: turns a req/rw/addr/count request into
// SETUP/PULSE/HOLD strobe cycles on the device bus, one word per period.
module ide_pio #(
  parameter int T_SETUP = 3,  // 1..15
  parameter int T_PULSE = 8,  // 2..15
  parameter int T_HOLD  = 2   // 1..15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        rw,
  input  logic [4:0]  addr,
  input  logic [8:0]  count,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        wdata_ready,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da,
  output logic [15:0] ide_data_out,
  input  logic [15:0] ide_data_in
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

  localparam logic [3:0] LD_SETUP = 4'(T_SETUP - 1);
  localparam logic [3:0] LD_PULSE = 4'(T_PULSE - 1);
  localparam logic [3:0] LD_HOLD  = 4'(T_HOLD - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_timer;
  logic [3:0]  w_timer_load;
  logic        r_rw;
  logic [4:0]  r_addr;
  logic [8:0]  r_remaining;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_rdata_valid;

  logic w_accept;
  logic w_tick_last;
  logic w_more;
  logic w_active;
  logic w_capture;

  assign w_accept    = (r_state == IDLE) && req;
  assign w_tick_last = (r_timer == 4'd0);
  assign w_more      = (r_remaining > 9'd1);
  assign w_active    = (r_state == SETUP) || (r_state == PULSE) || (r_state == HOLD);
  // Device releases its bus when the strobe rises, so sample on the last low cycle.
  assign w_capture   = (r_state == PULSE) && w_tick_last && r_rw;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_timer_load = 4'd0;
    unique case (r_state)
      IDLE:  if (req) w_state_next = SETUP;
      SETUP: if (w_tick_last) w_state_next = PULSE;
      PULSE: if (w_tick_last) w_state_next = HOLD;
      HOLD:  if (w_tick_last) w_state_next = w_more ? SETUP : DONE;
      DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    unique case (w_state_next)
      SETUP:   w_timer_load = LD_SETUP;
      PULSE:   w_timer_load = LD_PULSE;
      HOLD:    w_timer_load = LD_HOLD;
      default: w_timer_load = 4'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_timer       <= 4'd0;
      r_rw          <= 1'b0;
      r_addr        <= 5'd0;
      r_remaining   <= 9'd0;
      r_wdata       <= 16'd0;
      r_rdata       <= 16'd0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_state_next != r_state)  r_timer <= w_timer_load;
      else if (r_timer != 4'd0)     r_timer <= r_timer - 4'd1;

      if (w_accept) begin
        r_rw        <= rw;
        r_addr      <= addr;
        r_remaining <= (count == 9'd0) ? 9'd1 : count;
      end else if ((r_state == HOLD) && w_tick_last && (r_remaining != 9'd0)) begin
        r_remaining <= r_remaining - 9'd1;
      end

      if (wdata_ready) r_wdata <= wdata;

      if (w_capture) r_rdata <= ide_data_in;
      r_rdata_valid <= w_capture;
    end
  end

  // Next write word is fetched on acceptance and at the end of every non-final HOLD.
  assign wdata_ready = (w_accept && !rw) ||
                       ((r_state == HOLD) && w_tick_last && w_more && !r_rw);

  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign rdata        = r_rdata;
  assign rdata_valid  = r_rdata_valid;
  assign ide_dior     = !((r_state == PULSE) && r_rw);
  assign ide_diow     = !((r_state == PULSE) && !r_rw);
  assign ide_cs       = w_active ? r_addr[4:3] : 2'b00;
  assign ide_da       = w_active ? r_addr[2:0] : 3'b000;
  assign ide_data_out = (w_active && !r_rw) ? r_wdata : 16'd0;

endmodule

// File: tb/tb_ide_pio.sv
// Bench for ide_pio: small ATA device model on the bus, scoreboard queues for
// read data and done timing, directed scenarios for timing, bursts and reset.
module tb_ide_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [8:0]  count = 9'd0;
  wire  [15:0] wdata;
  logic        busy, done, wdata_ready, rdata_valid;
  logic [15:0] rdata;
  logic        ide_dior, ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;
  logic [15:0] ide_data_out;
  logic [15:0] ide_data_in;

  ide_pio dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .addr(addr), .count(count),
    .wdata(wdata), .busy(busy), .done(done), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .ide_dior(ide_dior), .ide_diow(ide_diow),
    .ide_cs(ide_cs), .ide_da(ide_da), .ide_data_out(ide_data_out), .ide_data_in(ide_data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- write data source ----------------
  logic [15:0] wbase = 16'd0;
  int          wd_idx = 0;
  int          n_wr = 0;
  assign wdata = wbase + wd_idx[15:0];

  always @(posedge clk) begin
    if (wdata_ready) begin
      #1;
      wd_idx++;
      n_wr++;
    end
  end

  // ---------------- device model ----------------
  function automatic logic [15:0] dev_pat(input int i);
    if (i == 0) return 16'h414c;
    if (i == 1) return 16'h4c42;
    return 16'(i) ^ 16'ha500;
  endfunction

  logic [15:0] dev_seccnt = 16'd0;
  int          dev_rd_left = 0, dev_rd_ptr = 0;
  int          dev_wr_left = 0, dev_wr_cnt = 0;
  logic [31:0] dev_wr_sum = 32'd0;
  int          dev_diow_cnt = 0;
  logic        p_dior = 1'b1, p_diow = 1'b1;
  wire  [4:0]  dev_a = {ide_cs, ide_da};

  always_comb begin
    ide_data_in = 16'd0;
    if (!ide_dior) begin
      case (dev_a)
        5'h10: ide_data_in = (dev_rd_left > 0) ? dev_pat(dev_rd_ptr) : 16'd0;
        5'h12: ide_data_in = dev_seccnt;
        5'h17: ide_data_in = 16'h0050 | ((dev_rd_left > 0 || dev_wr_left > 0) ? 16'h0008 : 16'h0000);
        default: ide_data_in = 16'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!p_diow && ide_diow) begin
      dev_diow_cnt++;
      case (dev_a)
        5'h12: dev_seccnt = ide_data_out;
        5'h17: begin
          if (ide_data_out == 16'h0020) begin dev_rd_left = 256; dev_rd_ptr = 0; end
          else if (ide_data_out == 16'h0030) dev_wr_left = 256;
        end
        5'h10: if (dev_wr_left > 0) begin
          dev_wr_left--;
          dev_wr_cnt++;
          dev_wr_sum = dev_wr_sum + 32'(ide_data_out);
        end
        default: ;
      endcase
    end
    if (!p_dior && ide_dior && dev_a == 5'h10 && dev_rd_left > 0) begin
      dev_rd_left--;
      dev_rd_ptr++;
    end
    p_dior = ide_dior;
    p_diow = ide_diow;
  end

  // ---------------- scoreboard monitor ----------------
  logic [15:0] exp_rd[$];
  int          exp_done[$];
  int          n_rv = 0, n_done = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rdata_valid) begin
        n_rv++;
        check("rdata_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) check("rdata", 32'(rdata), 32'(exp_rd.pop_front()));
      end
      if (done) begin
        n_done++;
        check("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) check("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
      end
      if (!ide_dior || !ide_diow) check("strobe_exclusive", 32'(ide_dior | ide_diow), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic access(input logic r, input logic [4:0] a, input logic [8:0] n,
                        input logic [15:0] wb);
    int words;
    words = (n == 9'd0) ? 1 : int'(n);
    @(posedge clk); #1;
    rw = r; addr = a; count = n; wbase = wb; wd_idx = 0; req = 1'b1;
    exp_done.push_back(cyc + 13 * words + 1);
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, first_low, nlow, b_wr, b_diow, b_rv, b_done;
    logic [31:0] sum;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dior", 32'(ide_dior), 32'd1);
    check("rst_diow", 32'(ide_diow), 32'd1);
    check("rst_cs_da", 32'({ide_cs, ide_da}), 32'd0);
    check("rst_data_out", 32'(ide_data_out), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_pulses", 32'({wdata_ready, rdata_valid}), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // single write to seccnt: strobe timing and address decode
    @(posedge clk); #1;
    rw = 1'b0; addr = 5'h12; count = 9'd1; wbase = 16'h0001; wd_idx = 0; req = 1'b1;
    rc = cyc; b_wr = n_wr;
    exp_done.push_back(rc + 14);
    first_low = -1; nlow = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) check("idle_cs_da", 32'({ide_cs, ide_da}), 32'd0);
      if (!ide_diow) begin
        if (first_low < 0) first_low = k;
        nlow++;
      end
      if (k == 5) begin
        check("wr_cs", 32'(ide_cs), 32'h2);
        check("wr_da", 32'(ide_da), 32'h2);
        check("wr_data_out", 32'(ide_data_out), 32'h0001);
      end
      if (k == 15) check("busy_after_done", 32'(busy), 32'd0);
      @(posedge clk); #1;
      req = 1'b0;
    end
    check("diow_first_low", 32'(first_low), 32'd4);
    check("diow_low_cycles", 32'(nlow), 32'd8);
    check("wr1_wdata_ready", 32'(n_wr - b_wr), 32'd1);
    check("dev_seccnt", 32'(dev_seccnt), 32'd1);

    // count 0 is one word
    access(1'b0, 5'h12, 9'd0, 16'h0007);
    check("cnt0_seccnt", 32'(dev_seccnt), 32'h7);

    // status read at idle device
    b_rv = n_rv; b_done = n_done;
    exp_rd.push_back(16'h0050);
    access(1'b1, 5'h17, 9'd1, 16'h0000);
    check("status_rv_count", 32'(n_rv - b_rv), 32'd1);
    check("status_done_count", 32'(n_done - b_done), 32'd1);

    // program lba/seccnt, read-sectors command, 256-word burst read
    access(1'b0, 5'h13, 9'd1, 16'h0000);
    access(1'b0, 5'h14, 9'd1, 16'h0000);
    access(1'b0, 5'h15, 9'd1, 16'h0000);
    access(1'b0, 5'h12, 9'd1, 16'h0001);
    access(1'b0, 5'h17, 9'd1, 16'h0020);
    b_rv = n_rv;
    for (int i = 0; i < 256; i++) exp_rd.push_back(dev_pat(i));
    access(1'b1, 5'h10, 9'd256, 16'h0000);
    check("burst_rd_rv_count", 32'(n_rv - b_rv), 32'd256);
    exp_rd.push_back(16'h0050);
    access(1'b1, 5'h17, 9'd1, 16'h0000);

    // write-sectors command, 256-word burst write
    access(1'b0, 5'h17, 9'd1, 16'h0030);
    b_wr = n_wr; b_diow = dev_diow_cnt;
    access(1'b0, 5'h10, 9'd256, 16'h1000);
    sum = 32'd0;
    for (int i = 0; i < 256; i++) sum = sum + 32'h1000 + 32'(i);
    check("burst_wr_ready_count", 32'(n_wr - b_wr), 32'd256);
    check("burst_wr_diow_count", 32'(dev_diow_cnt - b_diow), 32'd256);
    check("burst_wr_dev_cnt", 32'(dev_wr_cnt), 32'd256);
    check("burst_wr_fifo_left", 32'(dev_wr_left), 32'd0);
    check("burst_wr_sum", dev_wr_sum, sum);
    exp_rd.push_back(16'h0050);
    access(1'b1, 5'h17, 9'd1, 16'h0000);

    // reset during the 5th PULSE cycle of a read
    b_rv = n_rv; b_done = n_done;
    @(posedge clk); #1;
    rw = 1'b1; addr = 5'h17; count = 9'd1; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_pulse_dior_low", 32'(ide_dior), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rst_pulse_dior", 32'(ide_dior), 32'd1);
    check("rst_pulse_busy", 32'(busy), 32'd0);
    check("rst_pulse_rdata", 32'(rdata), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (16) @(posedge clk);
    check("rst_pulse_no_rv", 32'(n_rv - b_rv), 32'd0);
    check("rst_pulse_no_done", 32'(n_done - b_done), 32'd0);
    exp_rd.push_back(16'h0050);
    access(1'b1, 5'h17, 9'd1, 16'h0000);

    // req hammered during a 3-word write burst
    b_wr = n_wr; b_diow = dev_diow_cnt; b_done = n_done;
    @(posedge clk); #1;
    rw = 1'b0; addr = 5'h12; count = 9'd3; wbase = 16'h0003; wd_idx = 0; req = 1'b1;
    exp_done.push_back(cyc + 40);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      rw = 1'b1; addr = 5'h17; count = 9'd5;
    end
    req = 1'b0;
    wait_idle();
    check("hammer_done_count", 32'(n_done - b_done), 32'd1);
    check("hammer_diow_count", 32'(dev_diow_cnt - b_diow), 32'd3);
    check("hammer_wr_ready", 32'(n_wr - b_wr), 32'd3);
    check("hammer_last_word", 32'(dev_seccnt), 32'h5);

    repeat (4) @(negedge clk);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ide_pio.md
IDE_PIO -- requirements
Module: ide_pio

Interface
REQ-001 T_SETUP, 3, clk cycles from address/cs valid to strobe assertion (1..15).
REQ-002 T_PULSE, 8, clk cycles strobe held low (2..15).
REQ-003 T_HOLD, 2, clk cycles address/data held after strobe release (1..15).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  start access; sampled only in IDLE.
REQ-007 rw  input  1  1 = read, 0 = write; captured with req.
REQ-008 addr  input  5  {cs[1:0], da[2:0]}; captured with req.
REQ-009 count  input  9  words in access, 1..256; 0 treated as 1; captured with req.
REQ-010 wdata  input  16  write word; sampled in the cycle wdata_ready=1.
REQ-011 busy  output  1  high from req acceptance until return to IDLE.
REQ-012 done  output  1  one-cycle pulse when the last word completes.
REQ-013 wdata_ready  output  1  one-cycle pulse fetching next write word.
REQ-014 rdata  output  16  last captured read word.
REQ-015 rdata_valid  output  1  one-cycle pulse per captured read word.
REQ-016 ide_dior, ide_diow  output  1 each  active-low strobes.
REQ-017 ide_cs  output  2; ide_da  output  3  device address.
REQ-018 ide_data_out  output  16  write data to device.
REQ-019 ide_data_in  input  16  read data from device.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, DONE.
REQ-021 IDLE: on req=1, latch rw/addr/count, set busy, go SETUP next cycle; if write, wdata_ready pulses in the acceptance cycle.
REQ-022 SETUP: drive ide_cs/ide_da from latched addr (and ide_data_out for writes) for exactly T_SETUP cycles, strobes high.
REQ-023 PULSE: drive ide_dior (read) or ide_diow (write) low for exactly T_PULSE cycles; address/data stable.
REQ-024 Read data SHALL be captured from ide_data_in on the final PULSE cycle, rdata_valid pulsing the next cycle; device clears its bus on strobe rise, so capture after release is forbidden.
REQ-025 HOLD: strobes high, address/data held for T_HOLD cycles; then decrement remaining count.
REQ-026 After HOLD, if remaining count > 0, return to SETUP with same address (burst to ATA_DATA 0x10); writes pulse wdata_ready in the last HOLD cycle.
REQ-027 After HOLD with remaining count = 0, enter DONE: done=1 for one cycle, busy=0 in the cycle after DONE, return to IDLE.
REQ-028 Per-word period SHALL be T_SETUP+T_PULSE+T_HOLD cycles (13 default); 256-word burst = 3328 cycles plus one acceptance and one DONE cycle.
REQ-029 req while busy=1 SHALL be ignored, not queued.
REQ-030 ide_dior and ide_diow SHALL never be low simultaneously and SHALL never be low outside PULSE.
REQ-031 In IDLE ide_cs=2'b00, ide_da=0, ide_data_out=0.
REQ-032 Remaining-count counter 9 bits; no wrap: decrement only when nonzero.
REQ-033 Timing counter 4 bits, reloaded on each state entry.

Reset
REQ-034 reset_n low SHALL immediately force: IDLE, ide_dior=ide_diow=1, ide_cs=0, ide_da=0, ide_data_out=0, rdata=0, busy=done=wdata_ready=rdata_valid=0.
REQ-035 Reset mid-PULSE SHALL deassert the strobe asynchronously with no done pulse; after release the block accepts new req normally.

Verification
REQ-036 Write addr 0x12, wdata 0x0001, count 1 -> diow low exactly 8 cycles beginning 4 cycles after req; cs=2'b10, da=3'b010; done 14 cycles after req; device seccnt=1.
REQ-037 Read addr 0x17 at idle device -> rdata=0x0050, one rdata_valid, one done.
REQ-038 Program lba 0, seccnt 1, command 0x20 to 0x17, then read addr 0x10 count 256 -> 256 rdata_valid pulses, first word 0x414c, second 0x4c42; subsequent status read 0x0050.
REQ-039 Command 0x30, write addr 0x10 count 256 with incrementing wdata -> 256 wdata_ready pulses, 256 diow pulses, device reports fifo empty.
REQ-040 reset_n low during 5th PULSE cycle of a read -> dior high same time step, busy=0, no rdata_valid/done; next req completes normally.
REQ-041 req asserted repeatedly during a burst -> exactly one done, word count unchanged.
